// File: rtl/fim_axi_master.sv
// Register-file access master: read, write and dump commands become single AXI4-Lite transactions.
// Build macro FIM_FAULT_MASK_EN: when defined, write data is XORed with cmd_fault_mask before it is sent.
module fim_axi_master #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [4:0]              cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH-1:0]   cmd_fault_mask,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [4:0]              rsp_addr,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic                    rsp_err,
    output logic                    rsp_last,

    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]              M_AXI_AWPROT,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY,
    input  logic [1:0]              M_AXI_BRESP,

    output logic                    M_AXI_ARVALID,
    input  logic                    M_AXI_ARREADY,
    output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]              M_AXI_ARPROT,
    input  logic                    M_AXI_RVALID,
    output logic                    M_AXI_RREADY,
    input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]              M_AXI_RRESP,

    output logic [2:0]              fsm_state
);

    // Every valid/ready pair: a transfer happens on a rising edge where both are high; once valid is
    // raised, it and its payload stay unchanged until that edge, and valid never waits on ready.

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        RSP     = 3'd5
    } state_t;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_DUMP  = 2'b10;
    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

    state_t                  state;
    state_t                  state_next;
    logic [4:0]              idx;
    logic                    dump;
    logic                    aw_done;
    logic                    w_done;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   wdata_in;

    function automatic logic [ADDR_WIDTH-1:0] reg_addr(input logic [4:0] i);
        reg_addr = BASE_ADDR + (ADDR_WIDTH'(i) << 2);
    endfunction

`ifdef FIM_FAULT_MASK_EN
    assign wdata_in = cmd_wdata ^ cmd_fault_mask;
`else
    logic unused_fault_mask;
    assign wdata_in          = cmd_wdata;
    assign unused_fault_mask = ^cmd_fault_mask;
`endif

    assign M_AXI_AWADDR = addr_q;
    assign M_AXI_ARADDR = addr_q;
    assign M_AXI_WDATA  = wdata_q;
    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;
    assign M_AXI_WSTRB  = '1;
    assign fsm_state    = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        cmd_ready     = 1'b0;
        rsp_valid     = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_BREADY  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_READ, OP_DUMP: state_next = RD_ADDR;
                        OP_WRITE:         state_next = WR_REQ;
                        default:          state_next = RSP;
                    endcase
                end
            end
            RD_ADDR: begin
                M_AXI_ARVALID = 1'b1;
                if (M_AXI_ARREADY) state_next = RD_DATA;
            end
            RD_DATA: begin
                M_AXI_RREADY = 1'b1;
                if (M_AXI_RVALID) state_next = RSP;
            end
            WR_REQ: begin
                // AW and W retire independently; leave once both have handshaken.
                M_AXI_AWVALID = !aw_done;
                M_AXI_WVALID  = !w_done;
                if ((aw_done || M_AXI_AWREADY) && (w_done || M_AXI_WREADY)) state_next = WR_RESP;
            end
            WR_RESP: begin
                M_AXI_BREADY = 1'b1;
                if (M_AXI_BVALID) state_next = RSP;
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    if (dump && (idx != LAST_IDX)) state_next = RD_ADDR;
                    else                           state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            idx      <= '0;
            dump     <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rsp_addr <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            rsp_last <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        idx     <= (cmd_op == OP_DUMP) ? 5'd0 : cmd_addr;
                        dump    <= (cmd_op == OP_DUMP);
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        addr_q  <= reg_addr((cmd_op == OP_DUMP) ? 5'd0 : cmd_addr);
                        wdata_q <= wdata_in;
                        if (cmd_op == 2'b11) begin
                            rsp_addr <= cmd_addr;
                            rsp_data <= '0;
                            rsp_err  <= 1'b1;
                            rsp_last <= 1'b1;
                        end
                    end
                end
                RD_DATA: begin
                    if (M_AXI_RVALID) begin
                        rsp_addr <= idx;
                        rsp_data <= M_AXI_RDATA;
                        rsp_err  <= (M_AXI_RRESP != 2'b00);
                        rsp_last <= !dump || (idx == LAST_IDX);
                    end
                end
                WR_REQ: begin
                    aw_done <= aw_done | M_AXI_AWREADY;
                    w_done  <= w_done | M_AXI_WREADY;
                end
                WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        rsp_addr <= idx;
                        rsp_data <= wdata_q;
                        rsp_err  <= (M_AXI_BRESP != 2'b00);
                        rsp_last <= 1'b1;
                    end
                end
                RSP: begin
                    if (rsp_ready && dump && (idx != LAST_IDX)) begin
                        idx    <= idx + 5'd1;
                        addr_q <= reg_addr(idx + 5'd1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fim_axi_master.sv
// Scoreboard bench for fim_axi_master: commands feed an expected-response queue, a monitor pops and
// compares, and a memory-backed AXI4-Lite slave checks addresses, data and handshake discipline.
module tb_fim_axi_master;

    localparam int             AW   = 32;
    localparam int             DW   = 32;
    localparam int             NR   = 32;
    localparam logic [AW-1:0]  BASE = '0;
    localparam int             EW   = DW + 8;

    logic clk, rst;
    logic cmd_valid, cmd_ready;
    logic [1:0] cmd_op;
    logic [4:0] cmd_addr;
    logic [DW-1:0] cmd_wdata, cmd_fault_mask;
    logic rsp_valid, rsp_ready, rsp_err, rsp_last;
    logic [4:0] rsp_addr;
    logic [DW-1:0] rsp_data;
    logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0] awprot, arprot, fsm_state;
    logic [DW-1:0] wdata, rdata;
    logic [DW/8-1:0] wstrb;
    logic [1:0] bresp, rresp;

    fim_axi_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_fault_mask(cmd_fault_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .rsp_last(rsp_last),
        .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready), .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot),
        .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
        .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_BRESP(bresp),
        .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready), .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot),
        .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
        .fsm_state(fsm_state)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [EW-1:0]    exp_q[$];
    logic [AW-1:0]    rd_exp_q[$];
    logic [AW+DW-1:0] wr_exp_q[$];
    logic [DW-1:0]    model_mem[NR];
    logic [DW-1:0]    slave_mem[NR];
    logic [1:0]       err_code[NR];

    bit busy = 0;
    bit lat_pending = 0;
    int lat_acc = 0;
    int ready_mode = 1;
    bit r_block = 0;
    bit stall_rand = 0;
    int stall_n = 0;
    int exp_ar = 0, exp_r = 0, exp_wr = 0;
    int tot_ar = 0, tot_r = 0, tot_aw = 0, tot_w = 0, tot_b = 0;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int slot(input logic [AW-1:0] a);
        return int'((a - BASE) >> 2) % NR;
    endfunction

    function automatic logic [EW-1:0] ent(input bit chk, input logic [4:0] a, input logic [DW-1:0] d,
                                          input bit e, input bit l);
        return {chk, a, d, e, l};
    endfunction

    // ---------------- AXI4-Lite slave ----------------
    logic [AW-1:0] s_araddr, s_awaddr, aw_addr_s;
    logic [DW-1:0] s_wdata, w_data_s;
    logic [2:0]    s_awprot, s_arprot;
    logic [DW/8-1:0] s_wstrb;
    bit ar_hs, r_hs, aw_hs, w_hs, b_hs;
    bit aw_got, w_got, r_pend;
    int r_wait, b_wait, awv_cnt;
    logic [AW-1:0] r_addr_s;
    logic [AW+DW-1:0] we;

    initial begin
        arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
        rdata = '0; rresp = '0; bresp = '0;
        aw_got = 0; w_got = 0; r_pend = 0; r_wait = 0; b_wait = 0; awv_cnt = 0;
        forever begin
            @(negedge clk);
            ar_hs = arvalid && arready;  r_hs = rvalid && rready;
            aw_hs = awvalid && awready;  w_hs = wvalid && wready;  b_hs = bvalid && bready;
            s_araddr = araddr; s_arprot = arprot; s_awaddr = awaddr; s_awprot = awprot;
            s_wdata = wdata; s_wstrb = wstrb;
            if (aw_hs) awv_cnt = 0;
            else if (awvalid) awv_cnt++;
            @(posedge clk);
            #1;
            if (!rst) begin
                arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
                aw_got = 0; w_got = 0; r_pend = 0; awv_cnt = 0;
                continue;
            end
            if (ar_hs) begin
                tot_ar++;
                check("arprot", s_arprot, 3'b000);
                if (rd_exp_q.size() == 0) check("ar_unexpected", 1, 0);
                else check("araddr", s_araddr, rd_exp_q.pop_front());
                r_pend = 1; r_addr_s = s_araddr;
                r_wait = (ready_mode == 0) ? $urandom_range(0, 2) : 0;
            end
            if (r_hs) begin
                tot_r++;
                rvalid = 0;
            end
            if (r_pend && !rvalid && !r_block) begin
                if (r_wait == 0) begin
                    rvalid = 1;
                    rdata  = slave_mem[slot(r_addr_s)];
                    rresp  = err_code[slot(r_addr_s)];
                    r_pend = 0;
                end else r_wait--;
            end
            if (aw_hs) begin
                tot_aw++;
                check("awprot", s_awprot, 3'b000);
                aw_got = 1; aw_addr_s = s_awaddr;
            end
            if (w_hs) begin
                tot_w++;
                check("wstrb", s_wstrb, {(DW/8){1'b1}});
                w_got = 1; w_data_s = s_wdata;
            end
            if (b_hs) begin
                tot_b++;
                bvalid = 0;
            end
            if (aw_got && w_got && !bvalid) begin
                if (b_wait == 0) begin
                    if (wr_exp_q.size() == 0) check("w_unexpected", 1, 0);
                    else begin
                        we = wr_exp_q.pop_front();
                        check("awaddr", aw_addr_s, we[AW+DW-1:DW]);
                        check("wdata", w_data_s, we[DW-1:0]);
                    end
                    slave_mem[slot(aw_addr_s)] = w_data_s;
                    bvalid = 1;
                    bresp  = err_code[slot(aw_addr_s)];
                    aw_got = 0; w_got = 0;
                    b_wait = (ready_mode == 0) ? $urandom_range(0, 2) : 0;
                end else b_wait--;
            end
            case (ready_mode)
                0: begin
                    arready = 1'($urandom_range(0, 1));
                    awready = 1'($urandom_range(0, 1));
                    wready  = 1'($urandom_range(0, 1));
                end
                2: begin
                    arready = 1; wready = 1;
                    awready = (awv_cnt >= 4);
                end
                default: begin
                    arready = 1; awready = 1; wready = 1;
                end
            endcase
        end
    end

    // ---------------- response ready driver ----------------
    int vcnt = 0;
    initial begin
        rsp_ready = 0;
        forever begin
            @(negedge clk);
            if (!rst) vcnt = 0;
            else if (rsp_valid && rsp_ready) begin
                vcnt = 0;
                if (stall_rand) stall_n = $urandom_range(0, 2);
            end else if (rsp_valid) vcnt++;
            @(posedge clk);
            #1;
            rsp_ready = (vcnt >= stall_n);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic p_arv, p_arr, p_awv, p_awr, p_wv, p_wr;
    logic [AW-1:0] p_araddr, p_awaddr;
    logic [DW-1:0] p_wdata;
    logic [EW-1:0] e;

    initial begin
        p_arv = 0; p_arr = 0; p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0;
        p_araddr = '0; p_awaddr = '0; p_wdata = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                p_arv = 0; p_awv = 0; p_wv = 0;
                continue;
            end
            if (busy) check("cmd_ready_busy", cmd_ready, 0);
            else      check("cmd_ready_idle", cmd_ready, 1);
            if ((arvalid || rready) || (awvalid || wvalid || bready))
                check("rd_wr_exclusive", (arvalid || rready) && (awvalid || wvalid || bready), 0);
            if (p_arv && !p_arr) check("ar_hold", {arvalid, araddr}, {1'b1, p_araddr});
            if (p_awv && !p_awr) check("aw_hold", {awvalid, awaddr}, {1'b1, p_awaddr});
            if (p_wv && !p_wr)   check("w_hold", {wvalid, wdata}, {1'b1, p_wdata});
            p_arv = arvalid; p_arr = arready; p_araddr = araddr;
            p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
            p_wv = wvalid;   p_wr = wready;   p_wdata = wdata;
            if (rsp_valid) begin
                if (lat_pending) begin
                    check("read_latency", 64'(cyc - lat_acc), 3);
                    lat_pending = 0;
                end
                if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
                else begin
                    e = exp_q[0];
                    check("rsp_addr", rsp_addr, e[EW-2 -: 5]);
                    check("rsp_err", rsp_err, e[1]);
                    check("rsp_last", rsp_last, e[0]);
                    if (e[EW-1]) check("rsp_data", rsp_data, e[DW+1:2]);
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) busy = 0;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_model(input logic [1:0] op, input logic [4:0] a,
                              input logic [DW-1:0] wd, input logic [DW-1:0] m);
        logic [DW-1:0] eff;
`ifdef FIM_FAULT_MASK_EN
        eff = wd ^ m;
`else
        eff = wd;
`endif
        case (op)
            2'b00: begin
                exp_q.push_back(ent(1, a, model_mem[a], err_code[a] != 0, 1));
                rd_exp_q.push_back(BASE + AW'(a) * 4);
                exp_ar++; exp_r++;
            end
            2'b01: begin
                exp_q.push_back(ent(1, a, eff, err_code[a] != 0, 1));
                wr_exp_q.push_back({BASE + AW'(a) * 4, eff});
                model_mem[a] = eff;
                exp_wr++;
            end
            2'b10: begin
                for (int i = 0; i < NR; i++) begin
                    exp_q.push_back(ent(1, 5'(i), model_mem[i], err_code[i] != 0, i == NR - 1));
                    rd_exp_q.push_back(BASE + AW'(i) * 4);
                    exp_ar++; exp_r++;
                end
            end
            default: exp_q.push_back(ent(0, a, '0, 1, 1));
        endcase
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [4:0] a, input logic [DW-1:0] wd,
                            input logic [DW-1:0] m, input bit lat);
        bit accepted = 0;
        cmd_valid = 1; cmd_op = op; cmd_addr = a; cmd_wdata = wd; cmd_fault_mask = m;
        for (int i = 0; i < 3000 && !accepted; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                accepted = 1;
                check("accept_only_when_drained", exp_q.size(), 0);
                push_model(op, a, wd, m);
                if (lat) begin
                    lat_pending = 1;
                    lat_acc = cyc;
                end
            end
            @(posedge clk);
            #1;
            if (accepted) busy = 1;
        end
        if (!accepted) check("cmd_accept_timeout", 0, 1);
        cmd_valid = 0;
    endtask

    task automatic wait_idle(input int max_cyc);
        bit done = 0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !busy) done = 1;
        end
        if (!done) check("idle_timeout", exp_q.size(), 0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_arvalid"}, arvalid, 0);
        check({tag, "_awvalid"}, awvalid, 0);
        check({tag, "_wvalid"}, wvalid, 0);
        check({tag, "_rready"}, rready, 0);
        check({tag, "_bready"}, bready, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_err_last"}, {rsp_err, rsp_last}, 0);
        check({tag, "_rsp_data_addr"}, {rsp_data, rsp_addr}, 0);
        check({tag, "_axi_addr_data"}, {awaddr, araddr, wdata}, 0);
    endtask

    // ---------------- main sequence ----------------
    int snap_aw, snap_w, snap_b, snap_ar;
    int rnd;
    logic [1:0] rop;
    bit got;

    initial begin
        rst = 0; cmd_valid = 0; cmd_op = 0; cmd_addr = 0; cmd_wdata = 0; cmd_fault_mask = 0;
        for (int i = 0; i < NR; i++) begin
            model_mem[i] = $urandom;
            slave_mem[i] = model_mem[i];
            err_code[i]  = 2'b00;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk);
        #1 rst = 1;

        // single read with an always-ready slave: address, data and minimum latency
        ready_mode = 1; stall_rand = 0; stall_n = 0;
        slave_mem[5] = 32'hDEADBEEF; model_mem[5] = 32'hDEADBEEF;
        send_cmd(2'b00, 5'd5, '0, '0, 1);
        wait_idle(200);

        // write with fault mask, then read it back
        send_cmd(2'b01, 5'd3, 32'h0000FFFF, 32'h00000001, 0);
        send_cmd(2'b00, 5'd3, '0, '0, 0);
        wait_idle(200);

        // W accepted well before AW
        ready_mode = 2;
        snap_aw = tot_aw; snap_w = tot_w; snap_b = tot_b;
        send_cmd(2'b01, 5'd12, 32'hA5A55A5A, 32'h0F0F0000, 0);
        wait_idle(200);
        check("late_aw_aw_count", tot_aw - snap_aw, 1);
        check("late_aw_w_count", tot_w - snap_w, 1);
        check("late_aw_b_count", tot_b - snap_b, 1);

        // reserved op: error response, no AXI traffic
        ready_mode = 0;
        snap_aw = tot_aw; snap_ar = tot_ar;
        send_cmd(2'b11, 5'd17, 32'h12345678, '0, 0);
        wait_idle(200);
        check("reserved_no_traffic", {16'(tot_aw - snap_aw), 16'(tot_ar - snap_ar)}, 0);

        // dump with an error on idx 7 and a 2-cycle stall per entry; a read waits behind it
        for (int i = 0; i < NR; i++) err_code[i] = 2'b00;
        err_code[7] = 2'b10;
        stall_n = 2;
        send_cmd(2'b10, 5'd9, '0, '0, 0);
        send_cmd(2'b00, 5'd4, '0, '0, 0);
        wait_idle(3000);
        err_code[7] = 2'b00;
        stall_n = 0;

        // reset while waiting in the read-data phase
        ready_mode = 1; r_block = 1;
        send_cmd(2'b00, 5'd20, '0, '0, 0);
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (rready) got = 1;
        end
        check("reached_read_data", got, 1);
        @(posedge clk);
        #1;
        rst = 0;
        exp_q.delete(); busy = 0; lat_pending = 0;
        exp_r--;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check_quiet("abort");
        @(posedge clk);
        #1;
        rst = 1; r_block = 0;
        @(negedge clk);
        check("post_reset_valids", {arvalid, awvalid, wvalid, rsp_valid}, 0);
        @(posedge clk);
        #1;
        send_cmd(2'b00, 5'd1, '0, '0, 0);
        wait_idle(200);

        // randomized traffic
        ready_mode = 0; stall_rand = 1;
        for (int i = 0; i < NR; i++)
            err_code[i] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        for (int n = 0; n < 40; n++) begin
            rnd = $urandom_range(0, 19);
            rop = (rnd < 8) ? 2'b00 : (rnd < 16) ? 2'b01 : (rnd < 18) ? 2'b11 : 2'b10;
            send_cmd(rop, 5'($urandom_range(0, 31)), DW'($urandom), DW'($urandom), 0);
            rnd = $urandom_range(0, 2);
            for (int k = 0; k < rnd; k++) begin
                @(posedge clk);
                #1;
            end
        end
        wait_idle(5000);
        repeat (5) @(posedge clk);

        check("exp_q_drained", exp_q.size(), 0);
        check("rd_addr_q_drained", rd_exp_q.size(), 0);
        check("wr_q_drained", wr_exp_q.size(), 0);
        check("total_ar", tot_ar, exp_ar);
        check("total_r", tot_r, exp_r);
        check("total_aw", tot_aw, exp_wr);
        check("total_w", tot_w, exp_wr);
        check("total_b", tot_b, exp_wr);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
